legv8_fetch_unit: RTL
=====================

# legv8_fetch_unit

Instruction-fetch stage for the LEGv8 microprocessor. Sits directly upstream of `Instruction_Memory_Thirty_Two_Bit`: owns the program counter, drives the memory `address`, and absorbs the memory's one-cycle synchronous read latency. Supports stall and branch redirect. Registers the returned `instruction` with its PC into the IF/ID pipeline register consumed by decode.

## Interface
- `ADDR_WIDTH`, 32: PC and `address` width. The PC is a word index: sequential step is +1.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset. Clears all state immediately.
- `address`  out  ADDR_WIDTH  to instruction memory. Equals the `pc` register.
- `instruction`  in  32  from instruction memory. Carries `mem[address]` as sampled at the previous rising edge.
- `stall`  in  1  decode hazard. Holds PC and IF/ID.
- `branch_taken`  in  1  redirect request. Single-cycle pulse.
- `branch_target`  in  ADDR_WIDTH  word index loaded into the PC when `branch_taken` is high.
- `if_id_instruction`  out  32  registered instruction.
- `if_id_pc`  out  ADDR_WIDTH  PC of `if_id_instruction`.
- `if_id_valid`  out  1  IF/ID holds a real instruction.

## Operation
Internal state:
- `pc`
- `fetch_pc`: address of the word currently on `instruction`.
- `fetch_valid`
- `hold_instr`: 32-bit skid buffer.
- `hold_valid`
- IF/ID registers.

Per rising edge, in priority order:
- **Reset:** `pc=RESET_PC`. `fetch_pc`, `fetch_valid`, `hold_valid`, `hold_instr` and all IF/ID outputs are 0.
- **Branch** (`branch_taken=1`, wins over `stall`):
  - `pc<=branch_target`.
  - `fetch_valid<=0`, which squashes the in-flight read.
  - `hold_valid<=0`.
  - `if_id_valid<=0`.
  - `if_id_instruction` and `if_id_pc` hold their values.
- **Stall** (`stall=1`):
  - `pc`, `fetch_pc` and IF/ID hold.
  - If `hold_valid=0` and `fetch_valid=1`: `hold_instr<=instruction`, `hold_valid<=1`. This is first stall cycle only.
  - Later stall cycles must not overwrite `hold_instr`, because by then `instruction` is `mem[pc]`, not `mem[fetch_pc]`.
- **Advance:**
  - `if_id_instruction <= hold_valid ? hold_instr : instruction`.
  - `if_id_pc<=fetch_pc`, `if_id_valid<=fetch_valid`.
  - `fetch_pc<=pc`, `fetch_valid<=1`, `pc<=pc+1`, `hold_valid<=0`.
- **PC wrap:** modulo 2^ADDR_WIDTH. All-ones +1 gives 0, with no flag.

## Timing
- After reset release, `address=RESET_PC` in cycle 0. The first `if_id_valid=1` appears after the 2nd rising edge, with `if_id_pc=RESET_PC`.
- Throughput: one instruction per cycle with no stall.
- **Branch penalty:** 2 bubbles.
  - Edge E: PC is loaded with `branch_target`.
  - Edge E+1: IF/ID receives `if_id_valid=0` (the squashed read).
  - Edge E+2: first IF/ID load with the target instruction.
- **Stall of N cycles:** IF/ID frozen for N edges. On the release edge, IF/ID takes `hold_instr`, and no instruction is skipped or duplicated.
- **`stall` while `fetch_valid=0`** (e.g. right after a branch): no capture. On release, IF/ID loads `if_id_valid=0`.
- **Asynchronous reset mid-stall or mid-branch:** all state returns to reset values within the same cycle, and any pending hold is discarded.
- `address` is purely registered, with no combinational path from `stall` or `branch_*`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds output `fetch_count` (32 bits, reset 0).
  - Increments on every edge that loads IF/ID with `fetch_valid=1`, i.e. advance edges only.
  - Wraps at 2^32.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
The bench preloads `mem[i]=10-i` for i in 0..15.

- **Reset and sequential fetch:** `RESET_PC=0`, no stall. IF/ID shows (pc,instr) = (0,10), (1,9), (2,8)…, with `if_id_valid` rising after the 2nd edge.
- **Stall:** 3-cycle stall asserted while `fetch_pc=4`. IF/ID holds (3,7). On release, the sequence continues (4,6), (5,5), with no gap or repeat.
- **Branch:** `branch_taken` pulse with target 9 while `pc=5`. IF/ID shows two `if_id_valid=0` cycles, then (9,1), (10,0).
- **Branch and stall together:** both high in the same cycle. Branch wins. Then (12,−2 as 32-bit 0xFFFFFFFE) appears for target 12 after 2 bubbles.
- **Reset mid-stall:** `reset` pulsed during a stall. `if_id_valid=0` and `address=0` immediately, and the sequence restarts at (0,10).
- **Perf counter** (`FETCH_PERF_CNT_EN`): 10 advance cycles plus 1 branch. `fetch_count` equals the number of valid IF/ID loads (10). Also check wrap: 0 → all-ones → 0.

Source files
------------

// File: rtl/legv8_fetch_unit.sv
// legv8_fetch_unit: LEGv8 instruction-fetch stage.
// Owns the word-indexed PC, drives the instruction memory address, absorbs
// the memory's one-cycle synchronous read latency with a one-word skid
// buffer, and registers (instruction, pc, valid) into the IF/ID register.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count output.
module legv8_fetch_unit #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           instruction,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           fetch_count,
`endif
  output logic [31:0]           if_id_instruction,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic                  if_id_valid
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_fetch_valid;
  logic [31:0]           r_hold_instr;
  logic                  r_hold_valid;
  logic [31:0]           r_if_id_instr;
  logic [ADDR_WIDTH-1:0] r_if_id_pc;
  logic                  r_if_id_valid;

  logic                  w_advance;
  logic [31:0]           w_fetched_instr;

  // A branch outranks a stall; only a cycle with neither moves the pipe.
  assign w_advance       = !branch_taken && !stall;
  // After a stall the word for fetch_pc lives in the skid buffer, since the
  // memory has since moved on to reading mem[pc].
  assign w_fetched_instr = r_hold_valid ? r_hold_instr : instruction;

  assign address           = r_pc;
  assign if_id_instruction = r_if_id_instr;
  assign if_id_pc          = r_if_id_pc;
  assign if_id_valid       = r_if_id_valid;

  // PC, in-flight fetch tracking, skid buffer and IF/ID register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_fetch_pc    <= '0;
      r_fetch_valid <= 1'b0;
      r_hold_instr  <= '0;
      r_hold_valid  <= 1'b0;
      r_if_id_instr <= '0;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      // Squash the in-flight read and any held word; IF/ID data is kept.
      r_pc          <= branch_target;
      r_fetch_valid <= 1'b0;
      r_hold_valid  <= 1'b0;
      r_if_id_valid <= 1'b0;
    end else if (stall) begin
      // Capture only on the first stall cycle: later cycles see mem[pc].
      if (!r_hold_valid && r_fetch_valid) begin
        r_hold_instr <= instruction;
        r_hold_valid <= 1'b1;
      end
    end else begin
      r_if_id_instr <= w_fetched_instr;
      r_if_id_pc    <= r_fetch_pc;
      r_if_id_valid <= r_fetch_valid;
      r_fetch_pc    <= r_pc;
      r_fetch_valid <= 1'b1;
      r_pc          <= r_pc + ADDR_WIDTH'(1);
      r_hold_valid  <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  assign fetch_count = r_fetch_count;

  // Count advance edges that load a real instruction into IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (w_advance && r_fetch_valid) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end
`endif

endmodule
